// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache-to-RAM arbiter: RAM handshake states, the word
// type and the arbitration owner encoding.
package cache_mem_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_NONE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_owner_t;

    localparam int STARVE_LIMIT_DEFAULT = 8;
    localparam int TIMEOUT_DEFAULT      = 64;

    // True when RAM reports that the driven access completes this cycle.
    function automatic logic isAccess(input ramstate_t state);
        return state == ACCESS;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Counts cycles a RAM request is held without completing and raises a sticky
// error once the wait gets too long or RAM itself reports an error.
module arb_watchdog
    import cache_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic done_i,
    input  logic ramerr_i,
    output logic err_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    // Next wait count (saturating) and sticky error; any idle or completing cycle restarts the count.
    always_comb begin
        count_d = '0;
        if (active_i && !done_i) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        end
        err_d = err_q | (count_d == CNT_MAX) | (active_i & ramerr_i);
    end

    // Counter and error flag registers, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for the icache/dcache pair: picks one cache request
// per transaction, drives the single RAM port and returns wait/data.
// Dcache has priority unless icache has been starved for STARVE_LIMIT grants.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_owner_t owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic dReq, starveOverride, grantD, grantI, ramAccess;

    assign dReq      = dREN | dWEN;
    assign ramAccess = isAccess(ramstate_t'(ramstate));

    // Effective owner this cycle: a held owner keeps the port while it requests; otherwise dcache wins unless icache is starved.
    always_comb begin
        starveOverride = (starve_q == STARVE_MAX) && iREN;
        grantD = 1'b0;
        grantI = 1'b0;
        if (nRST) begin
            case (owner_q)
                ARB_D:   grantD = dReq;
                ARB_I:   grantI = iREN;
                default: begin
                    grantD = dReq && !starveOverride;
                    grantI = !grantD && iREN;
                end
            endcase
        end
    end

    // Next owner: a completion or a dropped request returns to ARB_NONE, otherwise the granted cache is held.
    always_comb begin
        owner_d = ARB_NONE;
        if (!ramAccess) begin
            if (grantD) begin
                owner_d = ARB_D;
            end else if (grantI) begin
                owner_d = ARB_I;
            end
        end
    end

    // Starvation count of dcache completions that happened while icache was waiting.
    always_comb begin
        starve_d = starve_q;
        if (!iREN || (grantI && ramAccess)) begin
            starve_d = '0;
        end else if (grantD && ramAccess && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Owner and starvation registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner_q  <= ARB_NONE;
            starve_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    assign ramREN   = grantD ? (dREN & ~dWEN) : grantI;
    assign ramWEN   = grantD & dWEN;
    assign ramaddr  = grantI ? iaddr : daddr;
    assign ramstore = dstore;
    assign iload    = ramload;
    assign dload    = ramload;
    assign iwait    = ~(grantI & ramAccess);
    assign dwait    = ~(grantD & ramAccess);

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) uWatchdog (
        .clk_i    (CLK),
        .rst_ni   (nRST),
        .active_i (grantD | grantI),
        .done_i   (ramAccess),
        .ramerr_i (ramstate_t'(ramstate) == ERROR),
        .err_o    (err)
    );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int STARVE_LIMIT = 8;
    localparam int TIMEOUT      = 64;
    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;

    logic        CLK, nRST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: who holds the port (0 none, 1 dcache, 2 icache),
    // how many dcache completions icache has sat through, how long the current
    // request has waited, and the sticky error.
    int mOwner = 0, mStarve = 0, mWait = 0, grant = 0;
    bit mErr = 0, acc = 0;

    cache_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic i, input logic [31:0] ia, input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs);
        iREN = i; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds; ramstate = rs;
        ramload = $urandom;
    endtask

    task automatic modelReset();
        mOwner = 0; mStarve = 0; mWait = 0; mErr = 0;
    endtask

    // Settle mid-cycle, decide who the model says is served, and compare every output.
    task automatic evalCycle();
        bit dq;
        logic expRen, expWen;
        logic [31:0] expAddr;
        @(negedge CLK);
        dq  = dREN || dWEN;
        acc = (ramstate == RS_ACCESS);
        if (!nRST) grant = 0;
        else if (mOwner == 1) grant = dq ? 1 : 0;
        else if (mOwner == 2) grant = iREN ? 2 : 0;
        else if (dq && !(mStarve == STARVE_LIMIT && iREN)) grant = 1;
        else if (iREN) grant = 2;
        else grant = 0;
        expRen  = (grant == 2) || (grant == 1 && dREN && !dWEN);
        expWen  = (grant == 1) && dWEN;
        expAddr = (grant == 2) ? iaddr : daddr;
        checkOutput("ramREN", ramREN, expRen);
        checkOutput("ramWEN", ramWEN, expWen);
        checkOutput("ramaddr", ramaddr, expAddr);
        checkOutput("ramstore", ramstore, dstore);
        checkOutput("iload", iload, ramload);
        checkOutput("dload", dload, ramload);
        checkOutput("iwait", iwait, !(grant == 2 && acc));
        checkOutput("dwait", dwait, !(grant == 1 && acc));
        checkOutput("err", err, mErr);
    endtask

    // Advance the model across the clock edge, then move to just after it.
    task automatic endCycle();
        if (!nRST) begin
            modelReset();
        end else begin
            mOwner = (grant == 0 || acc) ? 0 : grant;
            if (!iREN || (grant == 2 && acc)) mStarve = 0;
            else if (grant == 1 && acc && mStarve < STARVE_LIMIT) mStarve++;
            if (grant != 0 && !acc) mWait = (mWait + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : mWait + 1;
            else mWait = 0;
            if (mWait == TIMEOUT - 1 || (grant != 0 && ramstate == RS_ERROR)) mErr = 1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        evalCycle();
        endCycle();
    endtask

    initial begin
        nRST = 1'b0;
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1, 32'h100, 32'h0, RS_ACCESS);
        @(posedge CLK);
        #1;

        // Reset holds strobes low and waits high even with requests present.
        evalCycle();
        checkOutput("rst ramREN", ramREN, 1'b0);
        checkOutput("rst ramWEN", ramWEN, 1'b0);
        checkOutput("rst iwait", iwait, 1'b1);
        checkOutput("rst dwait", dwait, 1'b1);
        checkOutput("rst err", err, 1'b0);
        endCycle();
        nRST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE);
        tick();

        // Simultaneous requests with zero-wait RAM: dcache first, icache next cycle.
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0, RS_ACCESS);
        evalCycle();
        checkOutput("t1 c0 dwait", dwait, 1'b0);
        checkOutput("t1 c0 ramaddr", ramaddr, 32'h100);
        endCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h100, 32'h0, RS_ACCESS);
        evalCycle();
        checkOutput("t1 c1 iwait", iwait, 1'b0);
        checkOutput("t1 c1 ramaddr", ramaddr, 32'h200);
        endCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE);
        tick();

        // Both caches hammering: eight dcache completions, then icache is forced in.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 32'h2000 + c, 1'b1, 1'b0, 32'h1000 + c, 32'h0, RS_ACCESS);
            evalCycle();
            checkOutput("starve dwait", dwait, (c == 8) ? 1'b1 : 1'b0);
            checkOutput("starve iwait", iwait, (c == 8) ? 1'b0 : 1'b1);
            endCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE);
        tick();

        // Write held through three BUSY cycles; icache arrives and must wait its turn.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(c >= 1, 32'h500, 1'b1, 1'b1, 32'h400, 32'hDEADBEEF, (c < 3) ? RS_BUSY : RS_ACCESS);
            evalCycle();
            checkOutput("wr ramWEN", ramWEN, 1'b1);
            checkOutput("wr ramREN", ramREN, 1'b0);
            checkOutput("wr ramstore", ramstore, 32'hDEADBEEF);
            checkOutput("wr dwait", dwait, (c == 3) ? 1'b0 : 1'b1);
            checkOutput("wr iwait", iwait, 1'b1);
            endCycle();
        end
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h400, 32'h0, RS_ACCESS);
        evalCycle();
        checkOutput("wr ifollow iwait", iwait, 1'b0);
        checkOutput("wr ifollow ramaddr", ramaddr, 32'h500);
        endCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE);
        tick();

        // RAM stuck BUSY: watchdog fires at cycle 63, transaction still completes later.
        for (int c = 0; c < 70; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, RS_BUSY);
            evalCycle();
            if (c == 62) checkOutput("wd c62 err", err, 1'b0);
            if (c == 63) checkOutput("wd c63 err", err, 1'b1);
            endCycle();
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, RS_ACCESS);
        evalCycle();
        checkOutput("wd late dwait", dwait, 1'b0);
        checkOutput("wd sticky err", err, 1'b1);
        endCycle();

        // Reset in the middle of a held icache transaction, then re-grant afterwards.
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY);
        tick();
        #2 nRST = 1'b0;
        #1;
        checkOutput("midrst ramREN", ramREN, 1'b0);
        checkOutput("midrst iwait", iwait, 1'b1);
        checkOutput("midrst dwait", dwait, 1'b1);
        checkOutput("midrst err", err, 1'b0);
        modelReset();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS);
        evalCycle();
        checkOutput("postrst ramREN", ramREN, 1'b1);
        checkOutput("postrst ramaddr", ramaddr, 32'h300);
        checkOutput("postrst iwait", iwait, 1'b0);
        endCycle();

        // Random traffic, including dropped requests and occasional RAM errors.
        for (int c = 0; c < 400; c++) begin
            int r;
            logic [1:0] rs;
            r  = int'($urandom_range(0, 9));
            rs = (r < 5) ? RS_ACCESS : (r < 8) ? RS_BUSY : (r == 8) ? RS_FREE : RS_ERROR;
            applyStimulus($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 3) == 0, $urandom, $urandom, rs);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
